// File: rtl/dual_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dual_core_mem_arbiter
//
// Purpose:
//   Shares a single RAM port between four requesters: the icache and dcache
//   ports of two cores. Data requests beat instruction requests. A round-robin
//   pointer picks which core wins within a class. Once a requester is granted,
//   it owns the RAM until the RAM reports ACCESS or the requester drops its
//   request.
//
// Handshake (request/wait):
//   A requester raises its request (iREN, or dREN/dWEN) and holds it, with
//   address and store data, until it samples wait=0. In that cycle the
//   transfer completes and, for reads, the load bus carries the data. While
//   the request is asserted and the transfer is not completing, wait reads 1.
//   If the requester drops its request early, the transaction is abandoned
//   and no completion is signalled.
//
// Ports:
//   CLK, nRST          clock (rising edge) and async active-low reset
//   iREN/iaddr         per-core instruction read request and address
//   iwait/iload        per-core instruction wait flag and read data
//   dREN/dWEN          per-core data read / write request
//   daddr/dstore       per-core data address and write data
//   dwait/dload        per-core data wait flag and read data
//   ramREN/ramWEN      RAM read / write enables
//   ramaddr/ramstore   RAM address and write data
//   ramload/ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   dbg_busy           1 while a grant is held (FSM in BUSY)
//   dbg_rr_ptr         current round-robin pointer (core index)
// -----------------------------------------------------------------------------
module dual_core_mem_arbiter #(
  parameter int WORD_W = 32,
  parameter int CORES  = 2   // only 2 is supported: core index is one bit
) (
  input  logic                         CLK,
  input  logic                         nRST,
  // instruction cache side
  input  logic [CORES-1:0]             iREN,
  input  logic [CORES-1:0][WORD_W-1:0] iaddr,
  output logic [CORES-1:0]             iwait,
  output logic [CORES-1:0][WORD_W-1:0] iload,
  // data cache side
  input  logic [CORES-1:0]             dREN,
  input  logic [CORES-1:0]             dWEN,
  input  logic [CORES-1:0][WORD_W-1:0] daddr,
  input  logic [CORES-1:0][WORD_W-1:0] dstore,
  output logic [CORES-1:0]             dwait,
  output logic [CORES-1:0][WORD_W-1:0] dload,
  // RAM side
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  input  logic [WORD_W-1:0]            ramload,
  input  logic [1:0]                   ramstate,
  // debug visibility of the arbiter FSM
  output logic                         dbg_busy,
  output logic                         dbg_rr_ptr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t state;
  logic   rr_ptr;     // core that wins ties within a class
  logic   gnt_core;   // latched owner core
  logic   gnt_d;      // latched owner class: 1 = data, 0 = instruction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [CORES-1:0] dreq;
  logic             other;
  logic [CORES-1:0] gnt_oh;
  logic             gnt_active;
  logic             gnt_write;
  logic             done;

  assign dreq   = dREN | dWEN;
  assign other  = ~rr_ptr;
  assign gnt_oh = {{(CORES-1){1'b0}}, 1'b1} << gnt_core;

  // Owner still requesting in its own class; dropping it aborts the grant.
  assign gnt_active = (state == BUSY) &&
                      (gnt_d ? dreq[gnt_core] : iREN[gnt_core]);

  // A data owner with dWEN set writes, even if dREN is also set.
  assign gnt_write = gnt_d & dWEN[gnt_core];

  assign done = gnt_active && (ramstate == RAM_ACCESS);

  // ---------------------------------------------------------------------------
  // Winner selection while IDLE
  // ---------------------------------------------------------------------------
  logic win_core;
  logic win_d;
  logic any_req;

  always_comb begin
    win_core = rr_ptr;
    win_d    = 1'b0;
    any_req  = 1'b1;
    if (dreq[rr_ptr]) begin
      win_core = rr_ptr;
      win_d    = 1'b1;
    end else if (dreq[other]) begin
      win_core = other;
      win_d    = 1'b1;
    end else if (iREN[rr_ptr]) begin
      win_core = rr_ptr;
      win_d    = 1'b0;
    end else if (iREN[other]) begin
      win_core = other;
      win_d    = 1'b0;
    end else begin
      any_req  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      gnt_core <= 1'b0;
      gnt_d    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_core <= win_core;
            gnt_d    <= win_d;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!gnt_active) begin
            // abandoned: no completion, pointer untouched
            state <= IDLE;
          end else if (done) begin
            state  <= IDLE;
            rr_ptr <= ~gnt_core;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_busy   = (state == BUSY);
  assign dbg_rr_ptr = rr_ptr;

  // ---------------------------------------------------------------------------
  // RAM drive: follows the owner's live inputs, only while it still requests.
  // ---------------------------------------------------------------------------
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (gnt_active) begin
      if (!gnt_d) begin
        ramREN  = 1'b1;
        ramaddr = iaddr[gnt_core];
      end else if (gnt_write) begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[gnt_core];
        ramstore = dstore[gnt_core];
      end else begin
        ramREN  = 1'b1;
        ramaddr = daddr[gnt_core];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cache-side wait and load
  // ---------------------------------------------------------------------------
  always_comb begin
    iwait = '0;
    dwait = '0;
    iload = '0;
    dload = '0;
    for (int c = 0; c < CORES; c++) begin
      iwait[c] = iREN[c] & ~(done & ~gnt_d & gnt_oh[c]);
      dwait[c] = dreq[c] & ~(done &  gnt_d & gnt_oh[c]);
      if (done && !gnt_d && gnt_oh[c]) begin
        iload[c] = ramload;
      end
      if (done && gnt_d && gnt_oh[c] && dREN[c] && !dWEN[c]) begin
        dload[c] = ramload;
      end
    end
  end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for dual_core_mem_arbiter. A requester-level model (owner id =
// core*2 + is_data, priority list scan) predicts every output each cycle;
// directed scenarios add literal expectations and a store-data queue.
// -----------------------------------------------------------------------------
module tb_dual_core_mem_arbiter;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [1:0]         iREN, dREN, dWEN, iwait, dwait;
  logic [1:0][W-1:0]  iaddr, daddr, dstore, iload, dload;
  logic               ramREN, ramWEN, dbg_busy, dbg_rr_ptr;
  logic [W-1:0]       ramaddr, ramstore, ramload;
  logic [1:0]         ramstate;

  dual_core_mem_arbiter #(.WORD_W(W), .CORES(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .dbg_busy(dbg_busy), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Requester-level model
  // ---------------------------------------------------------------------------
  bit m_busy;
  int m_owner;   // core*2 + (1 if data)
  bit m_rr;

  function automatic bit req_of(input int id, input logic [1:0] ir, input logic [1:0] dr);
    return (id % 2) ? dr[id/2] : ir[id/2];
  endfunction

  // Scan requesters in priority order: data(rr), data(other), instr(rr), instr(other)
  function automatic int pick(input bit rr, input logic [1:0] ir, input logic [1:0] dr);
    int order[4];
    order[0] = int'(rr) * 2 + 1;
    order[1] = int'(!rr) * 2 + 1;
    order[2] = int'(rr) * 2;
    order[3] = int'(!rr) * 2;
    for (int k = 0; k < 4; k++)
      if (req_of(order[k], ir, dr)) return order[k];
    return -1;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_rr    <= 1'b0;
    end else if (!m_busy) begin
      if (pick(m_rr, iREN, dREN | dWEN) >= 0) begin
        m_busy  <= 1'b1;
        m_owner <= pick(m_rr, iREN, dREN | dWEN);
      end
    end else if (!req_of(m_owner, iREN, dREN | dWEN)) begin
      m_busy <= 1'b0;
    end else if (ramstate == 2'd2) begin
      m_busy <= 1'b0;
      m_rr   <= (m_owner < 2);   // core 0 finished -> core 1 next
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin : cmp
    logic [1:0]        e_iwait, e_dwait;
    logic [1:0][W-1:0] e_iload, e_dload;
    logic              e_ren, e_wen;
    logic [W-1:0]      e_addr, e_store;
    int                c;
    bit                isd;
    e_iwait = iREN;
    e_dwait = dREN | dWEN;
    e_iload = '0;
    e_dload = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    if (m_busy && req_of(m_owner, iREN, dREN | dWEN)) begin
      c   = m_owner / 2;
      isd = (m_owner % 2) == 1;
      if (!isd) begin
        e_ren = 1'b1; e_addr = iaddr[c];
      end else if (dWEN[c]) begin
        e_wen = 1'b1; e_addr = daddr[c]; e_store = dstore[c];
      end else begin
        e_ren = 1'b1; e_addr = daddr[c];
      end
      if (ramstate == 2'd2) begin
        if (isd) e_dwait[c] = 1'b0; else e_iwait[c] = 1'b0;
        if (e_ren) begin
          if (isd) e_dload[c] = ramload; else e_iload[c] = ramload;
        end
      end
    end
    check("m_iwait", iwait, e_iwait);
    check("m_dwait", dwait, e_dwait);
    check("m_iload", iload, e_iload);
    check("m_dload", dload, e_dload);
    check("m_ramREN", ramREN, e_ren);
    check("m_ramWEN", ramWEN, e_wen);
    check("m_ramaddr", ramaddr, e_addr);
    check("m_ramstore", ramstore, e_store);
    check("m_busy", dbg_busy, m_busy);
    check("m_rr_ptr", dbg_rr_ptr, m_rr);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    clear_inputs();
    nRST = 1'b0;

    // T1: request held through reset, then immediate ACCESS
    iREN[0] = 1'b1; iaddr[0] = 32'h0000_0040;
    @(negedge CLK);
    check("t1_rst_ramREN", ramREN, 1'b0);
    check("t1_rst_iwait0", iwait[0], 1'b1);
    tick();
    nRST = 1'b1;
    tick();
    ramstate = 2'd2; ramload = 32'hDEAD_BEEF;
    @(negedge CLK);
    check("t1_ramREN", ramREN, 1'b1);
    check("t1_ramaddr", ramaddr, 32'h40);
    check("t1_iwait0", iwait[0], 1'b0);
    check("t1_iload0", iload[0], 32'hDEAD_BEEF);
    tick();
    clear_inputs();
    tick();

    // T2: data beats instruction, one IDLE bubble, then instruction
    do_reset();
    iREN[0] = 1'b1; iaddr[0] = 32'h200;
    dREN[1] = 1'b1; daddr[1] = 32'h300;
    tick();
    @(negedge CLK);
    check("t2_ramaddr_d1", ramaddr, 32'h300);
    check("t2_iwait0_a", iwait[0], 1'b1);
    tick();
    ramstate = 2'd2; ramload = 32'h55;
    @(negedge CLK);
    check("t2_dwait1", dwait[1], 1'b0);
    check("t2_dload1", dload[1], 32'h55);
    check("t2_iwait0_b", iwait[0], 1'b1);
    tick();
    dREN[1] = 1'b0; ramstate = 2'd0;
    @(negedge CLK);
    check("t2_bubble_ramREN", ramREN, 1'b0);
    check("t2_bubble_iwait0", iwait[0], 1'b1);
    tick();
    ramstate = 2'd2; ramload = 32'h66;
    @(negedge CLK);
    check("t2_ramaddr_i0", ramaddr, 32'h200);
    check("t2_iload0", iload[0], 32'h66);
    tick();
    clear_inputs();

    // T3: both cores write continuously, ACCESS every other cycle
    do_reset();
    dWEN = 2'b11;
    daddr[0] = 32'h10; dstore[0] = 32'hA0;
    daddr[1] = 32'h20; dstore[1] = 32'hB1;
    exp_q.push_back(32'hA0); exp_q.push_back(32'hB1);
    exp_q.push_back(32'hA0); exp_q.push_back(32'hB1);
    for (int i = 0; i < 8; i++) begin
      ramstate = (i % 2) ? 2'd2 : 2'd0;
      @(negedge CLK);
      if (ramWEN && ramstate == 2'd2) begin
        if (exp_q.size() == 0) begin
          check("t3_extra_write", 1'b1, 1'b0);
        end else begin
          exp_v = exp_q.pop_front();
          check("t3_ramstore", ramstore, exp_v);
        end
      end
      tick();
    end
    check("t3_queue_left", exp_q.size(), 0);
    clear_inputs();

    // T4: dREN+dWEN together -> write wins
    dREN[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h100; dstore[0] = 32'h1234;
    tick();
    @(negedge CLK);
    check("t4_ramWEN", ramWEN, 1'b1);
    check("t4_ramREN", ramREN, 1'b0);
    check("t4_ramstore", ramstore, 32'h1234);
    check("t4_dwait0_a", dwait[0], 1'b1);
    tick();
    ramstate = 2'd2; ramload = 32'hFFFF;
    @(negedge CLK);
    check("t4_dwait0_b", dwait[0], 1'b0);
    check("t4_dload0", dload[0], 32'h0);
    tick();
    clear_inputs();

    // T5: core1 instruction read, ERROR retried three times
    iREN[1] = 1'b1; iaddr[1] = 32'h500;
    tick();
    for (int k = 0; k < 3; k++) begin
      ramstate = 2'd3;
      @(negedge CLK);
      check("t5_err_iwait1", iwait[1], 1'b1);
      check("t5_err_ramREN", ramREN, 1'b1);
      tick();
    end
    ramstate = 2'd2; ramload = 32'h77;
    @(negedge CLK);
    check("t5_iwait1", iwait[1], 1'b0);
    check("t5_iload1", iload[1], 32'h77);
    tick();
    clear_inputs();
    @(negedge CLK);
    check("t5_rr_ptr", dbg_rr_ptr, 1'b0);
    tick();

    // T6: granted dREN[1] dropped mid-transaction
    iREN[0] = 1'b1; iaddr[0] = 32'h700;
    dREN[1] = 1'b1; daddr[1] = 32'h600;
    tick();
    @(negedge CLK);
    check("t6_ramaddr", ramaddr, 32'h600);
    tick();
    dREN[1] = 1'b0;
    @(negedge CLK);
    check("t6_abort_ramREN", ramREN, 1'b0);
    check("t6_abort_iwait0", iwait[0], 1'b1);
    tick();
    @(negedge CLK);
    check("t6_idle", dbg_busy, 1'b0);
    check("t6_rr_kept", dbg_rr_ptr, 1'b0);
    tick();
    ramstate = 2'd2; ramload = 32'h99;
    @(negedge CLK);
    check("t6_iload0", iload[0], 32'h99);
    tick();
    clear_inputs();

    // T7: reset pulsed during a transaction
    iREN[1] = 1'b1; iaddr[1] = 32'h800;
    tick();
    @(negedge CLK);
    check("t7_ramREN_busy", ramREN, 1'b1);
    tick();
    nRST = 1'b0;
    #1;
    check("t7_rst_ramREN", ramREN, 1'b0);
    check("t7_rst_iwait1", iwait[1], 1'b1);
    check("t7_rst_idle", dbg_busy, 1'b0);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    check("t7_after_rst_ramREN", ramREN, 1'b0);
    tick();
    ramstate = 2'd2; ramload = 32'hAB;
    @(negedge CLK);
    check("t7_iload1", iload[1], 32'hAB);
    tick();
    clear_inputs();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_core_mem_arbiter.md
Name: dual_core_mem_arbiter

Overview:
- Shares one RAM port between the instruction and data cache ports of two cores (four requesters total).
- Sits between each core's icache/dcache cache-side ports and the RAM.
- Data requests have priority over instruction requests; a round-robin pointer chooses between cores.
- Holds a grant for the whole RAM transaction and returns wait/load handshakes to the owning cache.

Parameters:
- WORD_W, 32, data and address width in bits.
- CORES, 2, number of cores; fixed at 2; other values are not supported.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  [CORES]  per-core instruction read request.
- iaddr  in  [CORES][WORD_W]  per-core instruction address.
- iwait  out  [CORES]  1 = instruction request not yet serviced.
- iload  out  [CORES][WORD_W]  instruction read data; valid when iREN=1 and iwait=0.
- dREN  in  [CORES]  per-core data read request.
- dWEN  in  [CORES]  per-core data write request.
- daddr  in  [CORES][WORD_W]  per-core data address.
- dstore  in  [CORES][WORD_W]  per-core write data.
- dwait  out  [CORES]  1 = data request not yet serviced.
- dload  out  [CORES][WORD_W]  data read data; valid when dREN=1 and dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset (nRST=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant registers cleared.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - All iload/dload=0.
  - iwait/dwait follow the wait rule below, so any asserted request reads wait=1.
- Wait rule, all cycles: wait for a requester = its request asserted AND NOT (requester granted AND state=BUSY AND ramstate=ACCESS).
- State IDLE:
  - No RAM enables are driven.
  - Winner selection: any dREN|dWEN beats any iREN. Within a class, core rr_ptr wins; otherwise the other core.
  - If any request is pending: latch winner index and type (I/D); next state BUSY.
  - If nothing is pending: stay IDLE.
- State BUSY:
  - RAM signals are driven combinationally from the latched requester's current inputs.
  - I-grant: ramREN=1, ramaddr=iaddr.
  - D-grant with dWEN=1: ramWEN=1, ramREN=0, ramaddr=daddr, ramstore=dstore. Write wins if dREN and dWEN are both set.
  - D-grant with only dREN=1: ramREN=1, ramaddr=daddr.
- Completion, ramstate==ACCESS in BUSY:
  - Granted wait=0 for exactly that cycle.
  - Granted load=ramload that cycle for reads; loads are 0 otherwise.
  - Next state IDLE; rr_ptr <= ~granted core.
- ramstate FREE, BUSY or ERROR in BUSY: hold the grant and keep driving the RAM. ERROR is retried; it is never reported as completion.
- Abort: if the granted requester deasserts its request in BUSY, drive no RAM enables, return to IDLE, leave rr_ptr unchanged, and do not complete.
- Latency:
  - Request seen in IDLE at cycle N; RAM enables from N+1.
  - Earliest completion is cycle N+1 if RAM reports ACCESS immediately.
  - One IDLE bubble between back-to-back transactions.
- A non-granted requester always sees wait=1 while requesting. Requests arriving mid-transaction are not preempted.
- Starvation bound: a data request waits at most one other-core data transaction after its core becomes rr_ptr.

Test Plan:
- Reset with iREN[0]=1 → ramREN=0, iwait[0]=1. Release reset; cycle 1 ramREN=1, ramaddr=iaddr[0]=0x0000_0040; ACCESS with ramload=0xDEAD_BEEF → iwait[0]=0, iload[0]=0xDEAD_BEEF.
- iREN[0]=1 and dREN[1]=1 in the same cycle, rr_ptr=0 → data granted first (ramaddr=daddr[1]), iwait[0]=1 throughout; instruction served next after one IDLE bubble.
- dWEN[0]=dWEN[1]=1 continuously, RAM ACCESS every other cycle → grants alternate 0,1,0,1; ramstore matches dstore of the granted core each time.
- dREN[0]=dWEN[0]=1, daddr=0x100, dstore=0x1234 → ramWEN=1, ramREN=0, ramstore=0x1234; dwait[0] drops on ACCESS.
- Grant core1 I-read, ramstate=ERROR for 3 cycles then ACCESS → iwait[1] stays 1 through ERROR and drops only on ACCESS; rr_ptr becomes 0.
- Granted dREN[1] deasserted mid-BUSY, plus a separate test with nRST pulsed low mid-BUSY → RAM enables drop the same cycle, state IDLE, no spurious wait=0 on any port.
